board_input_cond: RTL and testbench
===================================

BOARD_INPUT_COND -- requirements
Module: board_input_cond

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 1000000, meaning debounce stability window in clk_i cycles; legal range >= 2.
REQ-002 SHALL have parameter SW_W, default 16, meaning number of slide-switch inputs.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  system clock (PLL output); all registers on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 btn_i  input  1  raw asynchronous push-button level.
REQ-007 sw_i  input  SW_W  raw asynchronous slide-switch levels.
REQ-008 btn_level_o  output  1  debounced button level.
REQ-009 btn_press_o  output  1  one-cycle pulse on debounced button 0->1; feeds the SoC irq_btn_i.
REQ-010 sw_o  output  SW_W  conditioned switch levels; feeds SoC GPIO inputs.
REQ-011 sw_change_o  output  1  one-cycle pulse when any sw_o bit changes.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each debounced channel SHALL hold a registered stable value and a counter of width ceil(log2(DB_LIMIT)).
REQ-014 Per channel, each edge where synced != stable: if counter == DB_LIMIT-1, stable <= synced and counter <= 0; else counter increments.
REQ-015 Per channel, each edge where synced == stable: counter <= 0 (any glitch restarts the window).
REQ-016 Counter SHALL never exceed DB_LIMIT-1; no wrap-around.
REQ-017 Latency: raw change held steady SHALL appear on debounced output after edge DB_LIMIT+1, counting the first edge sampling the new raw value as edge 0.
REQ-018 Raw pulses or bounces shorter than DB_LIMIT synced cycles SHALL produce no output change.
REQ-019 Button channel: fixed states IDLE(stable=0), WAIT_HI(stable=0, counting), PRESSED(stable=1), WAIT_LO(stable=1, counting); transitions per REQ-014/015.
REQ-020 btn_press_o SHALL be high for exactly the one cycle following the edge at which btn_level_o goes 0->1; no pulse on release.
REQ-021 sw_change_o SHALL be high for exactly the one cycle following any edge at which sw_o changes; simultaneous multi-bit changes SHALL give one pulse.
REQ-022 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-023 While rst_i high at an edge, all synchronizer flops, stable values, counters and outputs SHALL become 0 (btn_level_o=0, btn_press_o=0, sw_o=0, sw_change_o=0).
REQ-024 Reset asserted mid-count SHALL abort the count; no pulse generated during or on exit from reset.
REQ-025 Inputs already high at reset release SHALL be reported per REQ-017 latency, generating btn_press_o / sw_change_o normally.

Configuration
REQ-026 Macro BOARD_INPUT_COND_SW_DEBOUNCE_EN defined: every sw_i bit SHALL be debounced per REQ-013..REQ-018.
REQ-027 Macro undefined: sw_o SHALL equal the 2-flop synchronized sw_i registered once (3-edge latency), no switch counters; sw_change_o behaviour unchanged; button always debounced.

Verification (DB_LIMIT=4, SW_W=16, macro defined unless stated)
REQ-028 btn_i 0->1 held 20 cycles -> btn_level_o rises after edge 5, btn_press_o high exactly one cycle, single pulse only.
REQ-029 btn_i high 3 cycles then low, repeated 5 times -> btn_level_o stays 0, btn_press_o never asserted.
REQ-030 sw_i 16'h0000->16'hA5A5 in one cycle, held -> sw_o=16'hA5A5 after edge 5, exactly one sw_change_o pulse.
REQ-031 btn_i high, rst_i pulsed 1 cycle at count 2 -> all outputs 0 during reset; btn_level_o rises 6 edges after release with one btn_press_o.
REQ-032 Macro undefined: sw_i bit0 0->1 -> sw_o=16'h0001 after edge 2, one sw_change_o pulse; 1-cycle glitch on bit1 propagates to sw_o.
REQ-033 btn_i held high then released for 10 cycles -> btn_level_o falls after edge 5, no btn_press_o pulse on release.

Source files
------------

// File: rtl/board_input_cond.sv
// rtl/board_input_cond.sv - push-button and slide-switch conditioning (sync, debounce, edge pulses)
// Optional feature macro: BOARD_INPUT_COND_SW_DEBOUNCE_EN (debounce every switch bit; otherwise sync + one register)
module board_input_cond #(
   parameter int DB_LIMIT = 1000000,
   parameter int SW_W     = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            btn_i,
   input  logic [SW_W-1:0] sw_i,
   output logic            btn_level_o,
   output logic            btn_press_o,
   output logic [SW_W-1:0] sw_o,
   output logic            sw_change_o
);

   localparam int CNT_W = $clog2(DB_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      PRESSED = 2'd2,
      WAIT_LO = 2'd3
   } btn_state_t;

   logic            btn_s1;
   logic            btn_s2;
   logic [SW_W-1:0] sw_s1;
   logic [SW_W-1:0] sw_s2;

   btn_state_t      btn_state;
   logic [CNT_W-1:0] btn_cnt;

   logic [SW_W-1:0] sw_next;

   // Two-flop synchronizers on every raw input before any other logic
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= btn_i;
         btn_s2 <= btn_s1;
         sw_s1  <= sw_i;
         sw_s2  <= sw_s1;
      end
   end

   // Button debounce FSM; a level flip is committed only after the synced value differs for DB_LIMIT edges
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_state   <= IDLE;
         btn_cnt     <= '0;
         btn_level_o <= 1'b0;
         btn_press_o <= 1'b0;
      end else begin
         btn_press_o <= 1'b0;
         case (btn_state)
            IDLE: begin
               btn_cnt <= '0;
               if (btn_s2) begin
                  btn_state <= WAIT_HI;
                  btn_cnt   <= CNT_ONE;
               end
            end
            WAIT_HI: begin
               if (!btn_s2) begin
                  btn_state <= IDLE;
                  btn_cnt   <= '0;
               end else if (btn_cnt == CNT_MAX) begin
                  btn_state   <= PRESSED;
                  btn_cnt     <= '0;
                  btn_level_o <= 1'b1;
                  btn_press_o <= 1'b1;
               end else begin
                  btn_cnt <= btn_cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               btn_cnt <= '0;
               if (!btn_s2) begin
                  btn_state <= WAIT_LO;
                  btn_cnt   <= CNT_ONE;
               end
            end
            WAIT_LO: begin
               if (btn_s2) begin
                  btn_state <= PRESSED;
                  btn_cnt   <= '0;
               end else if (btn_cnt == CNT_MAX) begin
                  btn_state   <= IDLE;
                  btn_cnt     <= '0;
                  btn_level_o <= 1'b0;
               end else begin
                  btn_cnt <= btn_cnt + CNT_ONE;
               end
            end
            default: begin
               btn_state <= IDLE;
               btn_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef BOARD_INPUT_COND_SW_DEBOUNCE_EN
   logic [CNT_W-1:0] sw_cnt      [SW_W];
   logic [CNT_W-1:0] sw_cnt_next [SW_W];

   // Per-bit debounce: sw_o itself is the stable value, counters restart on any agreement
   always_comb begin
      sw_next = sw_o;
      for (int i = 0; i < SW_W; i++) begin
         sw_cnt_next[i] = '0;
         if (sw_s2[i] != sw_o[i]) begin
            if (sw_cnt[i] == CNT_MAX) begin
               sw_next[i] = sw_s2[i];
            end else begin
               sw_cnt_next[i] = sw_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Switch debounce counters
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < SW_W; i++) begin
         if (rst_i) begin
            sw_cnt[i] <= '0;
         end else begin
            sw_cnt[i] <= sw_cnt_next[i];
         end
      end
   end
`else
   // Without debounce the switches are just the synchronized levels
   always_comb begin
      sw_next = sw_s2;
   end
`endif

   // Registered switch outputs; one change pulse however many bits move together
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_o        <= '0;
         sw_change_o <= 1'b0;
      end else begin
         sw_o        <= sw_next;
         sw_change_o <= |(sw_next ^ sw_o);
      end
   end

endmodule

// File: tb/tb_board_input_cond.sv
// tb/tb_board_input_cond.sv - randomized and directed bench for board_input_cond against a run-length reference model
module tb_board_input_cond;

   localparam int DB = 4;
   localparam int W  = 16;
`ifdef BOARD_INPUT_COND_SW_DEBOUNCE_EN
   localparam int SW_EDGE = DB + 1;
`else
   localparam int SW_EDGE = 2;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          btn_i = 1'b0;
   logic [W-1:0]  sw_i  = '0;
   logic          btn_level_o;
   logic          btn_press_o;
   logic [W-1:0]  sw_o;
   logic          sw_change_o;

   int vectors    = 0;
   int miscompares = 0;
   int press_cnt  = 0;
   int chg_cnt    = 0;
   int level_hi   = 0;

   // reference model state: raw history two deep, committed levels, run lengths of disagreement
   logic          m_b1, m_b2, m_lvl, m_press;
   logic [W-1:0]  m_s1, m_s2, m_sw;
   logic          m_chg;
   int            run_b;
   int            run_s [W];

   board_input_cond #(.DB_LIMIT(DB), .SW_W(W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .btn_i       (btn_i),
      .sw_i        (sw_i),
      .btn_level_o (btn_level_o),
      .btn_press_o (btn_press_o),
      .sw_o        (sw_o),
      .sw_change_o (sw_change_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic b, input logic [W-1:0] s);
      logic          seen_b;
      logic [W-1:0]  seen_s;
      logic [W-1:0]  nxt;
      if (r) begin
         m_b1 = 0; m_b2 = 0; m_lvl = 0; m_press = 0; run_b = 0;
         m_s1 = '0; m_s2 = '0; m_sw = '0; m_chg = 0;
         for (int i = 0; i < W; i++) run_s[i] = 0;
      end else begin
         seen_b = m_b2; m_b2 = m_b1; m_b1 = b;
         seen_s = m_s2; m_s2 = m_s1; m_s1 = s;
         m_press = 0;
         if (seen_b != m_lvl) begin
            run_b++;
            if (run_b == DB) begin
               m_lvl   = seen_b;
               m_press = seen_b;
               run_b   = 0;
            end
         end else begin
            run_b = 0;
         end
`ifdef BOARD_INPUT_COND_SW_DEBOUNCE_EN
         nxt = m_sw;
         for (int i = 0; i < W; i++) begin
            if (seen_s[i] != m_sw[i]) begin
               run_s[i]++;
               if (run_s[i] == DB) begin
                  nxt[i]   = seen_s[i];
                  run_s[i] = 0;
               end
            end else begin
               run_s[i] = 0;
            end
         end
`else
         nxt = seen_s;
`endif
         m_chg = (nxt != m_sw);
         m_sw  = nxt;
      end
   endtask

   task automatic step(input logic r, input logic b, input logic [W-1:0] s);
      rst_i = r; btn_i = b; sw_i = s;
      @(posedge clk_i);
      model_edge(r, b, s);
      #1;
      check("btn_level", 32'(btn_level_o), 32'(m_lvl));
      check("btn_press", 32'(btn_press_o), 32'(m_press));
      check("sw_o",      32'(sw_o),        32'(m_sw));
      check("sw_change", 32'(sw_change_o), 32'(m_chg));
      press_cnt += int'(btn_press_o);
      chg_cnt   += int'(sw_change_o);
      level_hi  += int'(btn_level_o);
   endtask

   initial begin
      logic          b;
      logic [W-1:0]  s;
      int            hold;

      // reset state
      repeat (3) step(1'b1, 1'b0, '0);
      check("rst_all_zero", {btn_level_o, btn_press_o, sw_change_o, sw_o}, 32'd0);
      repeat (4) step(1'b0, 1'b0, '0);

      // held press: level rises at edge DB+1, one pulse
      press_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, '0);
         if (i == DB) check("press_edge_before", 32'(btn_level_o), 32'd0);
         if (i == DB + 1) check("press_edge_at", 32'(btn_level_o), 32'd1);
      end
      check("press_single_pulse", press_cnt, 1);

      // release: level falls at edge DB+1, no pulse
      press_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, '0);
         if (i == DB) check("release_before", 32'(btn_level_o), 32'd1);
         if (i == DB + 1) check("release_at", 32'(btn_level_o), 32'd0);
      end
      check("release_no_pulse", press_cnt, 0);

      // short bounces never pass
      press_cnt = 0; level_hi = 0;
      for (int k = 0; k < 5; k++) begin
         repeat (3) step(1'b0, 1'b1, '0);
         repeat (3) step(1'b0, 1'b0, '0);
      end
      check("bounce_no_pulse", press_cnt, 0);
      check("bounce_no_level", level_hi, 0);

      // multi-bit switch change: one pulse
      chg_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 16'hA5A5);
         if (i == SW_EDGE - 1) check("sw_before", 32'(sw_o), 32'h0000);
         if (i == SW_EDGE) check("sw_at", 32'(sw_o), 32'hA5A5);
      end
      check("sw_single_change", chg_cnt, 1);
      repeat (10) step(1'b0, 1'b0, '0);

`ifndef BOARD_INPUT_COND_SW_DEBOUNCE_EN
      // no debounce: bit0 after edge 2, one-cycle glitch on bit1 gets through
      chg_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 16'h0001);
         if (i == 2) check("nodb_bit0", 32'(sw_o), 32'h0001);
      end
      check("nodb_one_change", chg_cnt, 1);
      step(1'b0, 1'b0, 16'h0003);
      step(1'b0, 1'b0, 16'h0001);
      step(1'b0, 1'b0, 16'h0001);
      check("nodb_glitch", 32'(sw_o), 32'h0003);
      repeat (4) step(1'b0, 1'b0, '0);
`endif

      // reset in mid-count, then the held button is reported after release
      press_cnt = 0;
      repeat (4) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, '0);
      check("midcount_rst", {btn_level_o, btn_press_o, sw_change_o, sw_o}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 1'b1, '0);
         if (k == DB + 1) check("post_rst_before", 32'(btn_level_o), 32'd0);
         if (k == DB + 2) check("post_rst_at", 32'(btn_level_o), 32'd1);
      end
      check("post_rst_pulse", press_cnt, 1);

      // random phase: variable hold lengths, sparse switch flips, occasional reset
      b = 1'b0; s = '0;
      for (int seg = 0; seg < 300; seg++) begin
         hold = int'($urandom_range(1, 8));
         b = ($urandom_range(0, 2) == 0) ? ~b : b;
         s = s ^ (W'($urandom) & W'($urandom) & W'($urandom));
         for (int c = 0; c < hold; c++) begin
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, b, s);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
